// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA sync generator:
//   - phase_t     : the four phases every scan line / frame walks through
//   - CNT_W       : width of the pixel and line counters
//   - MAX_TOTAL   : largest period the counters can represent
//   - DEF_*       : default 640x480@60 timing (25.175 MHz pixel clock)
//   - phase_total : sum of the four phase lengths of one axis
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int phase_total(input int len_active, input int len_front,
                                       input int len_sync, input int len_back);
        return len_active + len_front + len_sync + len_back;
    endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// -----------------------------------------------------------------------------
// vga_phase_counter
// One axis of the VGA raster: a counter that runs 0..TOTAL-1 and a 4-phase
// FSM (ACTIVE, FRONT, SYNC, BACK) that tracks which part of the period the
// counter is in. Used once for pixels within a line and once for lines
// within a frame.
// Ports:
//   clk        : clock, rising-edge
//   rst        : asynchronous active-high reset (count 0, phase ACTIVE)
//   advance    : step the counter/FSM on this clock
//   count      : registered count value
//   state_next : phase the FSM takes at the next edge, lets the parent
//                register decoded outputs in step with the counter
//   wrap       : high when advance is set and the count is at TOTAL-1
// -----------------------------------------------------------------------------
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int LEN_ACTIVE = DEF_H_VISIBLE,
    parameter int LEN_FRONT  = DEF_H_FRONT,
    parameter int LEN_SYNC   = DEF_H_SYNC,
    parameter int LEN_BACK   = DEF_H_BACK,
    parameter int W          = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] count,
    output phase_t       state_next,
    output logic         wrap
);

    localparam int TOTAL = phase_total(LEN_ACTIVE, LEN_FRONT, LEN_SYNC, LEN_BACK);

    // Last count value of each phase; the FSM leaves a phase on the advance
    // that moves the counter past that value.
    localparam logic [W-1:0] LAST_ACTIVE = W'(LEN_ACTIVE - 1);
    localparam logic [W-1:0] LAST_FRONT  = W'(LEN_ACTIVE + LEN_FRONT - 1);
    localparam logic [W-1:0] LAST_SYNC   = W'(LEN_ACTIVE + LEN_FRONT + LEN_SYNC - 1);
    localparam logic [W-1:0] LAST_COUNT  = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    phase_t       state_q, state_d;

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        wrap    = 1'b0;
        if (advance) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            case (state_q)
                ACTIVE:  if (count_q == LAST_ACTIVE) state_d = FRONT;
                FRONT:   if (count_q == LAST_FRONT)  state_d = SYNC;
                SYNC:    if (count_q == LAST_SYNC)   state_d = BACK;
                BACK:    if (count_q == LAST_COUNT)  state_d = ACTIVE;
                default: state_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= ACTIVE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count      = count_q;
    assign state_next = state_d;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator: pixel/line counters, active-low sync pulses,
// display-area flag and a once-per-frame tick for game logic.
// Ports:
//   Clk           : sole clock, rising-edge
//   Reset         : asynchronous active-high reset
//   CounterX      : current pixel column, 0..H_TOTAL-1
//   CounterY      : current line, 0..V_TOTAL-1
//   inDisplayArea : high inside the visible window
//   vga_h_sync    : active-low horizontal sync
//   vga_v_sync    : active-low vertical sync
//   PixelEn       : high on cycles where the counters advance
//   FrameTick     : one-cycle pulse on the first cycle showing (0, V_VISIBLE)
// Build option:
//   VGA_PIXEL_DIV_EN : when defined, the pixel rate is Clk/2 (PixelEn toggles,
//                      low on the first cycle after reset); otherwise PixelEn
//                      is constantly high.
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [CNT_W-1:0] CounterX,
    output logic [CNT_W-1:0] CounterY,
    output logic             inDisplayArea,
    output logic             vga_h_sync,
    output logic             vga_v_sync,
    output logic             PixelEn,
    output logic             FrameTick
);

    localparam int H_TOTAL = phase_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = phase_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] V_LAST_ACTIVE = CNT_W'(V_VISIBLE - 1);

    // The counters are CNT_W bits wide; a longer period cannot be represented.
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
        $error("vga_sync_gen: H_TOTAL exceeds the counter range");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
        $error("vga_sync_gen: V_TOTAL exceeds the counter range");
    end

    logic   pixel_en;
    logic   h_wrap;
    logic   v_wrap_unused;
    phase_t h_state_next;
    phase_t v_state_next;

`ifdef VGA_PIXEL_DIV_EN
    // Divide-by-two pixel enable. The phase resets to 0 so the first cycle
    // after reset release does not advance the raster.
    logic div_phase_q, div_phase_d;

    always_comb begin
        div_phase_d = ~div_phase_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_phase_q <= 1'b0;
        end else begin
            div_phase_q <= div_phase_d;
        end
    end

    assign pixel_en = div_phase_q;
`else
    assign pixel_en = 1'b1;
`endif

    assign PixelEn = pixel_en;

    vga_phase_counter #(
        .LEN_ACTIVE (H_VISIBLE),
        .LEN_FRONT  (H_FRONT),
        .LEN_SYNC   (H_SYNC),
        .LEN_BACK   (H_BACK),
        .W          (CNT_W)
    ) u_h_counter (
        .clk        (Clk),
        .rst        (Reset),
        .advance    (pixel_en),
        .count      (CounterX),
        .state_next (h_state_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps only on the pixel that ends a line.
    vga_phase_counter #(
        .LEN_ACTIVE (V_VISIBLE),
        .LEN_FRONT  (V_FRONT),
        .LEN_SYNC   (V_SYNC),
        .LEN_BACK   (V_BACK),
        .W          (CNT_W)
    ) u_v_counter (
        .clk        (Clk),
        .rst        (Reset),
        .advance    (h_wrap),
        .count      (CounterY),
        .state_next (v_state_next),
        .wrap       (v_wrap_unused)
    );

    // Decoded outputs are registered from the next-state phases so they
    // change on the same edge as the counters they describe.
    logic disp_q, disp_d;
    logic h_sync_q, h_sync_d;
    logic v_sync_q, v_sync_d;
    logic frame_tick_q, frame_tick_d;

    always_comb begin
        disp_d       = (h_state_next == ACTIVE) && (v_state_next == ACTIVE);
        h_sync_d     = (h_state_next != SYNC);
        v_sync_d     = (v_state_next != SYNC);
        // Fires only on the advance that enters (0, V_VISIBLE), so it stays
        // one Clk wide even when the counters hold on following cycles.
        frame_tick_d = h_wrap && (CounterY == V_LAST_ACTIVE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disp_q       <= 1'b1;
            h_sync_q     <= 1'b1;
            v_sync_q     <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            disp_q       <= disp_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign inDisplayArea = disp_q;
    assign vga_h_sync    = h_sync_q;
    assign vga_v_sync    = v_sync_q;
    assign FrameTick     = frame_tick_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, 48, horizontal back-porch pixels.
REQ-005 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, 2, vertical sync-pulse lines.
REQ-008 Parameter V_BACK, 33, vertical back-porch lines.
REQ-009 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 Reset  input  1  asynchronous, active-high reset.
REQ-011 CounterX  output  10  current pixel column, 0..H_TOTAL-1.
REQ-012 CounterY  output  10  current line, 0..V_TOTAL-1.
REQ-013 inDisplayArea  output  1  high when CounterX<H_VISIBLE and CounterY<V_VISIBLE.
REQ-014 vga_h_sync  output  1  active-low horizontal sync.
REQ-015 vga_v_sync  output  1  active-low vertical sync.
REQ-016 PixelEn  output  1  high on Clk cycles in which counters advance.
REQ-017 FrameTick  output  1  one-Clk pulse at start of vertical blanking, for game-logic update.

Function
REQ-018 H_TOTAL = sum of H_* (default 800), V_TOTAL = sum of V_* (default 525); each SHALL be <= 1024, checked at elaboration.
REQ-019 Horizontal FSM states H_ACTIVE (X 0..639), H_FRONT (640..655), H_SYNC (656..751), H_BACK (752..799); transitions only at phase boundaries when PixelEn=1.
REQ-020 Vertical FSM states V_ACTIVE (Y 0..479), V_FRONT (480..489), V_SYNC (490..491), V_BACK (492..524); advances only on the PixelEn cycle in which CounterX wraps H_TOTAL-1 -> 0.
REQ-021 CounterX increments by 1 per PixelEn cycle; H_TOTAL-1 wraps to 0; CounterY increments on X wrap; V_TOTAL-1 wraps to 0.
REQ-022 All outputs registered; inDisplayArea, vga_h_sync, vga_v_sync SHALL always decode the CounterX/CounterY values presented in the same cycle (zero skew, no pipeline lag).
REQ-023 vga_h_sync low iff horizontal state H_SYNC; vga_v_sync low iff vertical state V_SYNC.
REQ-024 FrameTick high for exactly one Clk cycle: the first cycle presenting (CounterX,CounterY)=(0,V_VISIBLE); never wider, even when PixelEn divides.
REQ-025 Counters and FSM states SHALL hold when PixelEn=0.

Reset
REQ-026 Reset asserted: CounterX=0, CounterY=0, states H_ACTIVE/V_ACTIVE, inDisplayArea=1, vga_h_sync=1, vga_v_sync=1, FrameTick=0, divider phase=0.
REQ-027 Reset mid-frame SHALL force REQ-026 values immediately, without waiting for a Clk edge; first advance occurs on the first PixelEn cycle after release.

Configuration
REQ-028 Macro VGA_PIXEL_DIV_EN defined: internal toggle divides Clk by 2; PixelEn=0 on the first Clk cycle after reset release, then alternates; counters advance every second Clk.
REQ-029 VGA_PIXEL_DIV_EN undefined: PixelEn constant 1; counters advance every Clk.

Structure
REQ-030 Package vga_timing_pkg SHALL hold the phase-state typedef (ACTIVE, FRONT, SYNC, BACK) and default 640x480@60 timing constants.
REQ-031 Sub-module vga_phase_counter (count, 4-phase FSM, advance enable, wrap flag, parameterised phase lengths) SHALL be instantiated twice: horizontal and vertical.

Verification
REQ-032 Macro off, release reset, 800 Clk -> CounterX=0, CounterY=1; inDisplayArea falls exactly at X=640.
REQ-033 Within one line -> vga_h_sync low for X 656..751 only, i.e. 96 consecutive cycles.
REQ-034 Run 420000 Clk -> exactly one FrameTick at (0,480); vga_v_sync low for 1600 cycles (Y 490..491).
REQ-035 Assert Reset at (300,200) -> outputs (0,0), inDisplayArea=1, both syncs 1 before next Clk edge.
REQ-036 Observe wrap (799,524) -> (0,0): inDisplayArea 0 -> 1, vga_v_sync stays 1.
REQ-037 Macro on, run 840000 Clk -> one full frame, counters change every 2nd Clk, FrameTick exactly one Clk wide.
